jedro_1_dram_slave: RTL

- Data-RAM responder for the core's data-memory bus (we/stb/addr/wdata/rdata/ack/err); it is the far end of the LSU data port.
- Holds a word-organised synchronous memory with byte-enable writes and a configurable number of wait states.
- Answers every strobed request with exactly one ack or err pulse.
- Used as the bench and FPGA data RAM behind the core's data port.

---
 rtl/jedro_1_dram_slave.sv | 122 ++++++++++++
 1 files changed

// File: rtl/jedro_1_dram_slave.sv
// Data-RAM responder for the core's data port: word memory, byte-enable writes, WAIT_STATES-cycle latency.
// Define JEDRO_1_DRAM_ERR_EN to answer out-of-range/misaligned requests with err instead of wrapping.
module jedro_1_dram_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [3:0]            ram_we,
  input  logic                  ram_stb,
  input  logic [DATA_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  ram_ack,
  output logic                  ram_err
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            we_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ack_q, err_q;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [DATA_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      idx;
  logic                  access;
  logic                  req_err;

  // Subtraction is modulo 2^DATA_WIDTH, so addresses below the base become huge offsets.
  assign offset = addr_q - BASE_ADDR;
  assign idx    = offset[IDX_W+1:2];
  assign access = (state_q == ST_WAIT) && (cnt_q == 4'd0);

`ifdef JEDRO_1_DRAM_ERR_EN
  assign req_err = (offset[DATA_WIDTH-1:IDX_W+2] != '0) || (offset[1:0] != 2'b00);
`else
  logic unused_offset_bits;
  assign unused_offset_bits = ^{offset[DATA_WIDTH-1:IDX_W+2], offset[1:0]};
  assign req_err = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ram_stb) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE && ram_stb) begin
        we_q    <= ram_we;
        addr_q  <= ram_addr;
        wdata_q <= ram_wdata;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (access) begin
        if (req_err) begin
          err_q <= 1'b1;
        end else begin
          ack_q <= 1'b1;
          if (we_q == 4'b0000) rdata_q <= mem[idx];
        end
      end
    end
  end

  // NOTE: the memory array has no reset; contents survive rstn_i, and reset forces IDLE so no write commits.
  always_ff @(posedge clk_i) begin
    if (access && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (we_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign ram_rdata = rdata_q;
  assign ram_ack   = ack_q;
  assign ram_err   = err_q;

endmodule
